// File: rtl/spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// spi_byte_receiver
//
// SPI peripheral-side receiver (mode 0, MSB first). The asynchronous SPI pins
// are oversampled in the clk domain, DATA_WIDTH-bit words are assembled and
// handed to local logic over a valid/ready handshake.
//
// Build option:
//   SPI_RX_FIFO_EN  defined   -> FIFO_DEPTH-entry circular word buffer
//                   undefined -> single holding register (FIFO_DEPTH unused)
//
// Ports:
//   clk, rst_n     system clock / asynchronous active-low reset
//   sclk, mosi     SPI clock and data from the remote board (asynchronous)
//   cs_n           SPI chip select, active low (asynchronous)
//   rx_data        head-of-queue word, valid while rx_valid=1
//   rx_valid       word available
//   rx_ready       consumer accepts; transfer on rx_valid & rx_ready
//   frame_active   receiver is inside a cs_n-low frame
//   overrun        1-cycle pulse: completed word dropped, buffer full
//   frame_error    1-cycle pulse: frame ended with a partial word
// -----------------------------------------------------------------------------
module spi_byte_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_active,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_n_sync_r;
  logic                   sclk_d_r;
  logic                   cs_n_d_r;

  logic sclk_s;
  logic mosi_s;
  logic cs_n_s;
  logic sclk_rise_s;
  logic cs_fall_s;
  logic cs_rise_s;

  // Receive FSM
  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-2:0] shift_r;
  logic [DATA_WIDTH-2:0] shift_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [CNT_W-1:0]      bit_cnt_nxt_s;
  logic                  push_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic                  frame_error_s;
  logic                  overrun_s;
  logic                  frame_active_r;
  logic                  rx_valid_r;

  // Pin synchronizers, preset to the idle bus levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_n_sync_r <= {SYNC_STAGES{1'b1}};
      sclk_d_r    <= 1'b0;
      cs_n_d_r    <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_n_sync_r <= {cs_n_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      cs_n_d_r    <= cs_n_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_n_s      = cs_n_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign cs_fall_s   = ~cs_n_s & cs_n_d_r;
  assign cs_rise_s   = cs_n_s & ~cs_n_d_r;
  assign push_data_s = {shift_r, mosi_s};

  // FSM next-state, shifter and bit counter
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    push_s        = 1'b0;
    frame_error_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bit_cnt_nxt_s = {CNT_W{1'b0}};
        if (cs_fall_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // The sclk edge is handled before a coincident cs_n rise, so a word
        // completed by that edge is still delivered.
        if (sclk_rise_s) begin
          shift_nxt_s = push_data_s[DATA_WIDTH-2:0];
          if (bit_cnt_r == LAST_BIT) begin
            push_s        = 1'b1;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          shift_nxt_s = shift_r;
        end
        if (cs_rise_s) begin
          state_nxt_s   = ST_IDLE;
          frame_error_s = (bit_cnt_nxt_s != {CNT_W{1'b0}});
          bit_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, shifter, counter and frame_active registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      shift_r        <= {(DATA_WIDTH-1){1'b0}};
      bit_cnt_r      <= {CNT_W{1'b0}};
      frame_active_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      shift_r        <= shift_nxt_s;
      bit_cnt_r      <= bit_cnt_nxt_s;
      frame_active_r <= (state_nxt_s == ST_ACTIVE);
    end
  end

`ifdef SPI_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W:0]        count_r;
  logic [PTR_W:0]        count_nxt_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  wr_en_s;

  // FIFO control: a pop frees a slot for a push in the same cycle
  always_comb begin
    pop_s     = rx_valid_r & rx_ready;
    full_s    = (count_r == FULL_CNT);
    wr_en_s   = push_s & (~full_s | pop_s);
    overrun_s = push_s & full_s & ~pop_s;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {(PTR_W+1){1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r    <= count_nxt_s;
      rx_valid_r <= (count_nxt_s != {(PTR_W+1){1'b0}});
    end
  end

  assign rx_data = mem_r[rd_ptr_r];
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [DATA_WIDTH-1:0] hold_r;
  logic                  pop_s;
  logic                  full_s;

  // Holding register is full while its word is valid and not being taken
  always_comb begin
    pop_s     = rx_valid_r & rx_ready;
    full_s    = rx_valid_r & ~rx_ready;
    overrun_s = push_s & full_s;
  end

  // Single-word holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r     <= {DATA_WIDTH{1'b0}};
      rx_valid_r <= 1'b0;
    end else if (push_s && !full_s) begin
      hold_r     <= push_data_s;
      rx_valid_r <= 1'b1;
    end else if (pop_s) begin
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= rx_valid_r;
    end
  end

  assign rx_data = hold_r;
`endif

  assign rx_valid     = rx_valid_r;
  assign frame_active = frame_active_r;
  assign overrun      = overrun_s;
  assign frame_error  = frame_error_s;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_receiver
//
// Scoreboard bench: stimulus tasks push expected words into exp_q as frames
// are sent; an independent monitor pops and compares on every accepted word
// and counts overrun / frame_error pulses.
// -----------------------------------------------------------------------------
module tb_spi_byte_receiver;

`ifdef SPI_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       sclk     = 1'b0;
  logic       mosi     = 1'b0;
  logic       cs_n     = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_active;
  logic       overrun;
  logic       frame_error;

  int         n_cmp    = 0;
  int         n_err    = 0;
  int         exp_ovr  = 0;
  int         exp_ferr = 0;
  int         act_ovr  = 0;
  int         act_ferr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  spi_byte_receiver #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_active(frame_active),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: compares every accepted word and counts error pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun === 1'b1) act_ovr++;
      if (frame_error === 1'b1) act_ferr++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no word", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", {24'h0, rx_data}, {24'h0, mon_exp});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outcome of one completed word, given the consumer state
  task automatic exp_word(input logic [7:0] d);
    if (rx_ready || exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr++;
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    logic [7:0] v;
    v = d;
    for (int i = 0; i < nbits; i++) begin
      mosi = v[7-i];
      tick(8);
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start;
    cs_n = 1'b0;
    tick(8);
    check("frame_active_in_frame", {31'h0, frame_active}, 32'h1);
  endtask

  task automatic frame_end;
    tick(8);
    cs_n = 1'b1;
    tick(12);
    check("frame_active_after_frame", {31'h0, frame_active}, 32'h0);
  endtask

  task automatic send_word(input logic [7:0] d);
    exp_word(d);
    send_bits(d, 8);
  endtask

  task automatic drain;
    rx_ready = 1'b1;
    tick(20);
    check("queue_drained", exp_q.size(), 32'h0);
    check("rx_valid_after_drain", {31'h0, rx_valid}, 32'h0);
  endtask

  initial begin
    // Power-on reset
    tick(3);
    check("reset_outputs", {rx_data, rx_valid, frame_active, overrun, frame_error}, 32'h0);
    rst_n = 1'b1;
    tick(5);

    // Single byte with consumer ready
    rx_ready = 1'b1;
    frame_start;
    send_word(8'hA5);
    frame_end;
    check("rx_valid_idle_a5", {31'h0, rx_valid}, 32'h0);

    // Three-byte frame buffered with consumer stalled
    rx_ready = 1'b0;
    frame_start;
    send_word(8'h3C);
    send_word(8'hFF);
    send_word(8'h00);
    frame_end;
    tick(20);
    check("rx_valid_held", {31'h0, rx_valid}, 32'h1);
    check("rx_data_head", {24'h0, rx_data}, 32'h3C);
    drain;

    // Five bytes into a stalled buffer
    rx_ready = 1'b0;
    frame_start;
    for (int b = 1; b <= 5; b++) send_word(8'(b));
    frame_end;
    check("rx_data_head_5b", {24'h0, rx_data}, 32'h01);
    drain;

    // Truncated frame: 5 bits of 0xF0, then a clean 0x81
    frame_start;
    send_bits(8'hF0, 5);
    exp_ferr++;
    frame_end;
    check("no_push_truncated", {31'h0, rx_valid}, 32'h0);
    frame_start;
    send_word(8'h81);
    frame_end;

    // Reset pulse in the middle of 0x55, then a clean 0x69
    frame_start;
    send_bits(8'h55, 4);
    tick(3);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    #1;
    check("reset_mid_byte", {rx_data, rx_valid, frame_active, overrun, frame_error}, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    frame_start;
    send_word(8'h69);
    frame_end;

    // sclk activity with chip select idle
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1;
      mosi = ~mosi;
      tick(8);
      check("frame_active_cs_idle", {31'h0, frame_active}, 32'h0);
      sclk = 1'b0;
      tick(8);
    end
    tick(10);
    check("rx_valid_cs_idle", {31'h0, rx_valid}, 32'h0);

    // Totals
    check("overrun_count", act_ovr, exp_ovr);
    check("frame_error_count", act_ferr, exp_ferr);
    check("queue_empty_end", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
